// File: rtl/ln_var_std_pipe.sv
// LayerNorm/RMSNorm stage-1 statistics back end: clamped variance + epsilon and a
// pipelined fixed-point square root, time-aligned with mean, pixel address and end-of-frame.
module ln_var_std_pipe #(
  parameter int                  DAT_DW   = 16,
  parameter int                  ACC_EXT  = 10,
  parameter int                  H_W      = 8,
  parameter int                  W_W      = 8,
  parameter int                  PIX_W    = 12,
  parameter int                  FRAC     = 10,
  parameter logic [2*DAT_DW+3:0] EPS      = '0,
  parameter int                  SQRT_LAT = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          rms_mode,
  input  logic [H_W-1:0]                h_in,
  input  logic [W_W-1:0]                w_in,
  input  logic                          mean_vld,
  input  logic signed [DAT_DW-1:0]      mean,
  input  logic [2*DAT_DW-1:0]           mean_square,
  input  logic                          sq_acc_vld,
  input  logic [2*DAT_DW+ACC_EXT-1:0]   sq_acc,
  output logic signed [DAT_DW-1:0]      mean_delay,
  output logic [2*DAT_DW+3:0]           variance,
  output logic [DAT_DW+FRAC+1:0]        std_dev,
  output logic                          std_vld,
  output logic [PIX_W-1:0]              wr_addr,
  output logic                          variance_done,
  output logic                          underflow,
  output logic                          saturated
);

  localparam int VAR_W = 2*DAT_DW + 4;
  localparam int STD_W = DAT_DW + 2 + FRAC;
  localparam int SQ_W  = 2*DAT_DW + ACC_EXT;
  localparam int DW    = SQ_W + 1;
  localparam int CW    = (DW > VAR_W + 1) ? DW : VAR_W + 1;
  localparam int L     = SQRT_LAT;
  localparam int BPS   = (STD_W + L - 1) / L;
  localparam int NB    = BPS * L;
  localparam int OPW   = 2 * NB;
  localparam int RW    = NB + 2;
  localparam logic [VAR_W-1:0] VAR_MAX = '1;

  typedef struct packed {
    logic             uf;
    logic             sat;
    logic [VAR_W-1:0] v;
  } var_t;

  typedef struct packed {
    logic [RW-1:0]  rem;
    logic [NB-1:0]  root;
    logic [OPW-1:0] op;
  } sq_t;

  typedef struct packed {
    logic                     vld;
    logic signed [DAT_DW-1:0] mn;
    logic [VAR_W-1:0]         vr;
    logic [PIX_W-1:0]         addr;
    logic                     done;
    sq_t                      sq;
  } stg_t;

  function automatic var_t clamp_var(input logic signed [DW-1:0] d);
    logic signed [CW-1:0] dx;
    var_t r;
    dx    = CW'(d);
    r.uf  = 1'b0;
    r.sat = 1'b0;
    r.v   = dx[VAR_W-1:0];
    if (dx < 0) begin
      r.uf = 1'b1;
      r.v  = '0;
    end else if ((dx >>> VAR_W) != '0) begin
      r.sat = 1'b1;
      r.v   = VAR_MAX;
    end
    return r;
  endfunction

  function automatic var_t add_eps(input var_t c);
    logic [VAR_W:0] sum;
    var_t r;
    r   = c;
    sum = {1'b0, c.v} + {1'b0, EPS};
    if (sum[VAR_W]) begin
      r.v   = VAR_MAX;
      r.sat = 1'b1;
    end else begin
      r.v = sum[VAR_W-1:0];
    end
    return r;
  endfunction

  // Restoring square root: BPS result bits, two operand bits consumed per bit.
  function automatic sq_t sqrt_stage(input sq_t s);
    sq_t r;
    logic [RW-1:0] trial;
    r = s;
    for (int i = 0; i < BPS; i++) begin
      r.rem = {r.rem[RW-3:0], r.op[OPW-1 -: 2]};
      r.op  = r.op << 2;
      trial = {r.root, 2'b01};
      if (r.rem >= trial) begin
        r.rem  = r.rem - trial;
        r.root = {r.root[NB-2:0], 1'b1};
      end else begin
        r.root = {r.root[NB-2:0], 1'b0};
      end
    end
    return r;
  endfunction

  logic                  beat, take, last_c;
  logic [2*DAT_DW-1:0]   ms_eff;
  logic signed [DW-1:0]  diff;
  var_t                  st0;
  logic [H_W+W_W-1:0]    area;
  logic [PIX_W-1:0]      tot_c, cnt_q, cnt_d, total_q, total_d;
  logic                  uf_q, uf_d, sat_q, sat_d;
  stg_t                  pipe_q [0:L];
  stg_t                  stg_d  [0:L];

  always_comb begin
    beat   = mean_vld & sq_acc_vld;
    take   = beat & ~clear;
    ms_eff = rms_mode ? '0 : mean_square;
    diff   = $signed({1'b0, sq_acc}) - $signed({{(ACC_EXT+1){1'b0}}, ms_eff});
    st0    = add_eps(clamp_var(diff));
  end

  // Frame size is latched on the first beat of a frame; a zero size acts as one.
  always_comb begin
    area    = {{W_W{1'b0}}, h_in} * {{H_W{1'b0}}, w_in};
    tot_c   = (cnt_q == '0) ? PIX_W'(area) : total_q;
    last_c  = (tot_c == '0) || (cnt_q == tot_c - 1'b1);
    cnt_d   = cnt_q;
    total_d = total_q;
    if (clear) begin
      cnt_d = '0;
    end else if (beat) begin
      if (cnt_q == '0) total_d = PIX_W'(area);
      cnt_d = last_c ? '0 : cnt_q + 1'b1;
    end
    uf_d  = clear ? 1'b0 : (uf_q  | (take & st0.uf));
    sat_d = clear ? 1'b0 : (sat_q | (take & st0.sat));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      total_q <= '0;
      uf_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      total_q <= total_d;
      uf_q    <= uf_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    stg_d[0].vld     = 1'b1;
    stg_d[0].mn      = rms_mode ? '0 : mean;
    stg_d[0].vr      = st0.v;
    stg_d[0].addr    = cnt_q;
    stg_d[0].done    = last_c;
    stg_d[0].sq.rem  = '0;
    stg_d[0].sq.root = '0;
    stg_d[0].sq.op   = OPW'(st0.v) << (2*FRAC);
    for (int s = 1; s <= L; s++) begin
      stg_d[s]    = pipe_q[s-1];
      stg_d[s].sq = sqrt_stage(pipe_q[s-1].sq);
    end
  end

  // Stage 0 captures the clamped variance; stages 1..L each resolve BPS root bits.
  // Data only advances with a valid, so the outputs hold while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= L; s++) pipe_q[s] <= '0;
    end else begin
      if (take) pipe_q[0] <= stg_d[0];
      else      pipe_q[0].vld <= 1'b0;
      for (int s = 1; s <= L; s++) begin
        if (pipe_q[s-1].vld && !clear) pipe_q[s] <= stg_d[s];
        else                           pipe_q[s].vld <= 1'b0;
      end
    end
  end

  assign std_vld       = pipe_q[L].vld;
  assign variance_done = pipe_q[L].vld & pipe_q[L].done;
  assign mean_delay    = pipe_q[L].mn;
  assign variance      = pipe_q[L].vr;
  assign std_dev       = pipe_q[L].sq.root[STD_W-1:0];
  assign wr_addr       = pipe_q[L].addr;
  assign underflow     = uf_q;
  assign saturated     = sat_q;

  logic unused_tail;
  assign unused_tail = ^{pipe_q[L].sq.rem, pipe_q[L].sq.op, pipe_q[L].sq.root >> STD_W};

endmodule
